mem_arbiter: RTL

- Arbitrates the icache and dcache miss/writeback traffic onto the single-port RAM; sits directly downstream of both caches' `cif` ports.
- Serializes one word transaction at a time; the dcache has priority, and a starvation guard bounds icache delay.
- Returns read data and per-cache wait signals to the caches, and counts RAM error responses.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU-side types used by the memory arbiter and its neighbours.
//   word_t     : 32-bit machine word (addresses and data).
//   ramstate_t : status reported by the single-port RAM each cycle.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises icache and dcache word transactions onto one single-port RAM.
//   The dcache normally wins. A starvation guard forces an icache grant after
//   STARVE_LIMIT consecutive dcache grants taken while the icache was waiting.
//   Every completed transaction returns to IDLE for one cycle before the next
//   grant. RAM ERROR responses are retried and counted in a saturating counter.
//
// Parameters
//   STARVE_LIMIT : dcache grants tolerated while the icache waits (>= 1)
// Ports
//   CLK, nRST            : clock (rising edge), async active-low reset
//   iREN, iaddr          : icache read request and word address
//   iwait, iload         : icache wait (1 = not complete) and read data
//   dREN, dWEN           : dcache read / write requests
//   daddr, dstore        : dcache word address and write data
//   dwait, dload         : dcache wait (1 = not complete) and read data
//   ramREN, ramWEN       : RAM read / write enables
//   ramaddr, ramstore    : RAM address and write data
//   ramload, ramstate    : RAM read data and status
//   errcnt               : saturating count of ERROR cycles while granted
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       iREN,
    input  word_t      iaddr,
    output logic       iwait,
    output word_t      iload,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       dwait,
    output word_t      dload,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  ramstate_t  ramstate,
    output logic [7:0] errcnt
);

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    arb_state_t          state;
    arb_state_t          next_state;
    logic [STREAK_W-1:0] streak;
    logic                dreq;
    logic                ireq;
    logic                granted;

    assign dreq    = dREN | dWEN;
    assign ireq    = iREN;
    assign granted = (state != IDLE);

    // Read data is broadcast to both caches; each only trusts it when its
    // own wait is low.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A dropped request abandons the grant even if ACCESS arrives in the
    // same cycle, so the cache that walked away never sees wait go low.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ireq && (streak == STREAK_MAX)) begin
                    next_state = IGRANT;
                end else if (dreq) begin
                    next_state = DGRANT;
                end else if (ireq) begin
                    next_state = IGRANT;
                end
            end
            DGRANT: begin
                if (!dreq || (ramstate == ACCESS)) begin
                    next_state = IDLE;
                end
            end
            IGRANT: begin
                if (!ireq || (ramstate == ACCESS)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (dWEN) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = 1'b1;
                end
                if (dreq && (ramstate == ACCESS)) begin
                    dwait = 1'b0;
                end
            end
            IGRANT: begin
                ramREN = 1'b1;
                ramaddr = iaddr;
                if (ireq && (ramstate == ACCESS)) begin
                    iwait = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // streak counts dcache wins that happened while the icache was already
    // asking; any icache grant wipes it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (next_state == IGRANT) begin
                streak <= '0;
            end else if ((next_state == DGRANT) && ireq && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            errcnt <= '0;
        end else if (granted && (ramstate == ERROR) && (errcnt != 8'hFF)) begin
            errcnt <= errcnt + 8'd1;
        end
    end

endmodule
